// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and bit-timing helpers.
// The parity constants and half_bit() are also used by the matching transmitter.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Offset from the start edge to the middle of the start bit.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, parity/framing/overrun flags and a
// one-word valid/ready holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 30,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad, stop_bad, complete;
    logic                 sample_c, stop_low_c;
    logic                 start_c, shift_c, par_c, stop_c, last_stop_c;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // The start bit is sampled half a bit in; every later sample is one full bit apart.
    assign sample_c   = (state == ST_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
    assign stop_low_c = stop_bad | ~rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (!rx_s) next_state = ST_START;
            ST_START:  if (sample_c) next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample_c && idx == DATA_LAST)
                           next_state = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (sample_c) next_state = ST_STOP;
            // A low stop with all-zero data is a line break: park until the line recovers.
            ST_STOP:   if (sample_c && idx == STOP_LAST)
                           next_state = (stop_low_c && shift == '0) ? ST_BREAK : ST_IDLE;
            ST_BREAK:  if (rx_s) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        start_c     = 1'b0;
        shift_c     = 1'b0;
        par_c       = 1'b0;
        stop_c      = 1'b0;
        last_stop_c = 1'b0;
        case (state)
            ST_IDLE:   start_c = ~rx_s;
            ST_DATA:   shift_c = sample_c;
            ST_PARITY: par_c   = sample_c;
            ST_STOP: begin
                stop_c      = sample_c;
                last_stop_c = sample_c && (idx == STOP_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == ST_IDLE || state == ST_BREAK || sample_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-frame accumulation; cleared on every start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift    <= '0;
            idx      <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            complete <= 1'b0;
        end else begin
            complete <= last_stop_c;
            if (start_c) begin
                shift    <= '0;
                idx      <= '0;
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (shift_c) begin
                shift <= {rx_s, shift[DATA_BITS-1:1]};
                idx   <= (idx == DATA_LAST) ? '0 : idx + IDX_W'(1);
            end
            if (par_c) begin
                par_bad <= (PARITY_MODE == PAR_ODD) ? ~(^{shift, rx_s}) : (^{shift, rx_s});
            end
            if (stop_c) begin
                stop_bad <= stop_low_c;
                idx      <= idx + IDX_W'(1);
            end
        end
    end

    // Holding register: a completing frame loads only if the slot is free or being drained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            busy        <= (next_state != ST_IDLE);
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift;
                    parity_err <= par_bad;
                    frame_err  <= stop_bad;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: an 8N1 and an 8E2 receiver driven by directed and random frames,
// checked against a frame-level reference model.
module tb_uart_rx_param;

    localparam int unsigned CPB  = 30;
    localparam int unsigned HALF = CPB / 2;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    logic clk, reset_n;
    logic rx_n, rdy_n, rx_e, rdy_e;
    logic [7:0] data_n, data_e;
    logic valid_n, perr_n, ferr_n, ovr_n, busy_n;
    logic valid_e, perr_e, ferr_e, ovr_e, busy_e;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;
    int cur_n    = 0;
    int cur_e    = 0;
    word_t obs_n[$], obs_e[$], exp_n[$], exp_e[$];

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                    .SYNC_STAGES(2)) u_n (
        .clk(clk), .reset_n(reset_n), .rx(rx_n), .rx_data(data_n), .rx_valid(valid_n),
        .rx_ready(rdy_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun_err(ovr_n),
        .busy(busy_n));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2),
                    .SYNC_STAGES(2)) u_e (
        .clk(clk), .reset_n(reset_n), .rx(rx_e), .rx_data(data_e), .rx_valid(valid_e),
        .rx_ready(rdy_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun_err(ovr_e),
        .busy(busy_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted word and every cycle with overrun high.
    always @(negedge clk) begin
        if (valid_n && rdy_n) obs_n.push_back('{data_n, perr_n, ferr_n});
        if (valid_e && rdy_e) obs_e.push_back('{data_e, perr_e, ferr_e});
        if (ovr_n) ovr_cnt++;
    end

    function automatic word_t model_n(input logic [7:0] d, input logic stop);
        return '{d, 1'b0, ~stop};
    endfunction

    // Even parity: the data bits plus the parity bit must hold an even number of ones.
    function automatic word_t model_e(input logic [7:0] d, input logic p, input logic s1,
                                      input logic s2);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        ones += int'(p);
        return '{d, (ones % 2) != 0, !(s1 && s2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_n(input logic b);
        rx_n = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic bit_e(input logic b);
        rx_e = b;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_n(input logic [7:0] d, input logic stop);
        bit_n(1'b0);
        for (int i = 0; i < 8; i++) bit_n(d[i]);
        bit_n(stop);
        rx_n = 1'b1;
    endtask

    task automatic send_e(input logic [7:0] d, input logic p, input logic s1);
        bit_e(1'b0);
        for (int i = 0; i < 8; i++) bit_e(d[i]);
        bit_e(p);
        bit_e(s1);
        bit_e(1'b1);
    endtask

    // Compare words accepted since the last call against the model queue.
    task automatic cmp_words(input string tag, input bit sel_e);
        if (!sel_e) begin
            chk({tag, "_count"}, 32'(obs_n.size()), 32'(exp_n.size()));
            for (int i = cur_n; i < exp_n.size(); i++)
                if (i < obs_n.size()) chk(tag, 32'(obs_n[i]), 32'(exp_n[i]));
            cur_n = exp_n.size();
        end else begin
            chk({tag, "_count"}, 32'(obs_e.size()), 32'(exp_e.size()));
            for (int i = cur_e; i < exp_e.size(); i++)
                if (i < obs_e.size()) chk(tag, 32'(obs_e[i]), 32'(exp_e[i]));
            cur_e = exp_e.size();
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s1;
        int         ovr_before;

        reset_n = 1'b1;
        rx_n = 1'b1; rx_e = 1'b1; rdy_n = 1'b1; rdy_e = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_n", 32'({data_n, valid_n, perr_n, ferr_n, ovr_n, busy_n}), 32'd0);
        chk("reset_e", 32'({data_e, valid_e, perr_e, ferr_e, ovr_e, busy_e}), 32'd0);
        reset_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        // Single word then two back-to-back frames.
        send_n(8'hA5, 1'b1); exp_n.push_back(model_n(8'hA5, 1'b1));
        send_n(8'h00, 1'b1); exp_n.push_back(model_n(8'h00, 1'b1));
        send_n(8'hFF, 1'b1); exp_n.push_back(model_n(8'hFF, 1'b1));
        repeat (4) @(posedge clk);
        #1 chk("idle_busy_n", 32'(busy_n), 32'd0);
        cmp_words("b2b_n", 1'b0);

        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            send_n(d, 1'b1);
            exp_n.push_back(model_n(d, 1'b1));
        end
        repeat (4) @(posedge clk);
        cmp_words("rand_n", 1'b0);

        // Even parity: good and bad parity bit on the same data.
        send_e(8'h3C, 1'b0, 1'b1); exp_e.push_back(model_e(8'h3C, 1'b0, 1'b1, 1'b1));
        send_e(8'h3C, 1'b1, 1'b1); exp_e.push_back(model_e(8'h3C, 1'b1, 1'b1, 1'b1));
        repeat (4) @(posedge clk);
        cmp_words("parity_e", 1'b0 ^ 1'b1);

        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            s1 = ($urandom_range(0, 3) != 0);
            send_e(d, p, s1);
            exp_e.push_back(model_e(d, p, s1, 1'b1));
        end
        repeat (4) @(posedge clk);
        cmp_words("rand_e", 1'b1);

        // Start glitch shorter than half a bit is rejected.
        rx_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("glitch_busy", 32'(busy_n), 32'd1);
        repeat (5) @(posedge clk);
        rx_n = 1'b1;
        repeat (HALF + 4) @(posedge clk);
        #1 chk("glitch_idle", 32'(busy_n), 32'd0);
        send_n(8'h5A, 1'b1); exp_n.push_back(model_n(8'h5A, 1'b1));
        repeat (4) @(posedge clk);
        cmp_words("glitch", 1'b0);

        // Overrun: second frame dropped while the first is held.
        rdy_n = 1'b0;
        ovr_before = ovr_cnt;
        send_n(8'h11, 1'b1);
        send_n(8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_pulses", 32'(ovr_cnt - ovr_before), 32'd1);
        chk("ovr_hold", 32'({valid_n, data_n}), 32'({1'b1, 8'h11}));
        rdy_n = 1'b1;
        exp_n.push_back(model_n(8'h11, 1'b1));
        @(posedge clk);
        #1 chk("ovr_drain", 32'(valid_n), 32'd0);
        cmp_words("ovr", 1'b0);

        // Line break: one word, stays busy until the line recovers.
        rx_n = 1'b0;
        repeat (15 * CPB) @(posedge clk);
        #1;
        chk("break_busy", 32'(busy_n), 32'd1);
        chk("break_words", 32'(obs_n.size() - cur_n), 32'd1);
        repeat (5 * CPB) @(posedge clk);
        rx_n = 1'b1;
        repeat (CPB) @(posedge clk);
        #1 chk("break_exit", 32'(busy_n), 32'd0);
        exp_n.push_back(model_n(8'h00, 1'b0));
        send_n(8'h81, 1'b1); exp_n.push_back(model_n(8'h81, 1'b1));
        repeat (4) @(posedge clk);
        cmp_words("break", 1'b0);

        // Reset in the middle of data bit 4 while a word is held.
        rdy_n = 1'b0;
        send_n(8'h33, 1'b1);
        repeat (4) @(posedge clk);
        #1 chk("pre_reset_hold", 32'({valid_n, data_n}), 32'({1'b1, 8'h33}));
        bit_n(1'b0);
        for (int i = 0; i < 4; i++) bit_n(1'b0);
        rx_n = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_n", 32'({data_n, valid_n, perr_n, ferr_n, ovr_n, busy_n}), 32'd0);
        chk("midreset_e", 32'({data_e, valid_e, perr_e, ferr_e, ovr_e, busy_e}), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        rdy_n = 1'b1;
        repeat (5 * CPB) @(posedge clk);
        send_n(8'hC3, 1'b1); exp_n.push_back(model_n(8'hC3, 1'b1));
        repeat (4) @(posedge clk);
        cmp_words("after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver. Adds:
- configurable data width, parity and stop bits
- mid-bit sampling with false-start rejection
- parity, framing and overrun error reporting
- valid/ready output handshake with a one-word holding register

It sits between the rx pad and the byte-stream consumer (command parser or FIFO).

Parameters:
CLKS_PER_BIT, 30, clk cycles per bit period; legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
SYNC_STAGES, 2, rx synchroniser depth; minimum 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous, idle high
rx_data  output  DATA_BITS  received word, LSB = first bit on the wire
rx_valid  output  1  rx_data and its flags are valid
rx_ready  input  1  consumer accepts the word
parity_err  output  1  qualified by rx_valid; parity mismatch on this word
frame_err  output  1  qualified by rx_valid; a stop bit sampled low
overrun_err  output  1  one-cycle pulse; a completed frame was dropped
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - outputs: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0
  - synchroniser flops preset to 1 (line idle); FSM = IDLE; counters = 0
  - reset mid-frame aborts the frame with no output; after release the receiver waits for a fresh start edge.
- Synchroniser: rx passes through SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s only.
- Bit timing:
  - HALF = CLKS_PER_BIT/2, truncating.
  - Sample k (k = 0 is the start bit) is taken when the frame has been active for HALF + k*CLKS_PER_BIT cycles, counted from the first cycle rx_s is low in IDLE.
  - The bit counter is 16 bits wide and reloads on every sample.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s == 0 -> START, counter cleared.
  - START: at sample 0, rx_s == 1 -> IDLE (glitch rejected, no output, no flags); rx_s == 0 -> DATA.
  - DATA: shifts rx_s into the word LSB-first for DATA_BITS samples. Then -> PARITY if PARITY_MODE != 0, else -> STOP.
  - PARITY: one sample.
    - Odd mode: error if XOR(data, parity bit) == 0.
    - Even mode: error if XOR(data, parity bit) == 1.
  - STOP: STOP_BITS samples; any low sample sets the frame's frame_err.
    - After the last stop sample -> IDLE on the next cycle, so back-to-back frames are received with no idle gap.
    - Exception: frame_err set and data all zero -> BREAK.
  - BREAK: remains until rx_s == 1, then -> IDLE. A held-low line produces exactly one frame, not repeated frames.
- Completion and handshake:
  - Completion is the cycle after the last stop sample.
  - If the holding register is free, or is freed by rx_valid && rx_ready in that same cycle: load rx_data, parity_err, frame_err; rx_valid = 1 next cycle.
  - Otherwise (rx_valid && !rx_ready): new frame is discarded, held word is unchanged, overrun_err pulses high for exactly one cycle.
  - rx_valid && rx_ready with no simultaneous completion: rx_valid falls next cycle.
  - Simultaneous accept and completion: rx_valid stays 1 and the new word replaces the old one; no overrun.
- Words with parity or frame errors are still delivered, with their flags set.
- Parity and frame flags change only when a word loads.

Decomposition:
- Package uart_pkg:
  - parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN)
  - rx FSM state enum
  - function computing HALF
  - the same constants reused by the matching transmitter
- Sub-module uart_sync: SYNC_STAGES-deep synchroniser with preset-to-1 reset. The rest stays in one module.

Test Plan:
1. CLKS_PER_BIT=30, 8N1, rx_ready=1, send 0xA5 -> rx_data = 0xA5, rx_valid high for 1 cycle, no flags. Repeat back-to-back 0x00, 0xFF -> both received in order.
2. PARITY_MODE=2 (even), send 0x3C with parity 0 -> parity_err = 0; send 0x3C with parity 1 -> rx_data = 0x3C, parity_err = 1.
3. rx low pulse of 10 cycles (< HALF), then idle -> no rx_valid, busy returns low by cycle HALF+1, next valid frame 0x5A received correctly.
4. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once at the 0x22 completion. Raise rx_ready -> 0x11 accepted, rx_valid falls.
5. Hold rx low for 20 bit periods -> exactly one word: rx_data = 0x00, frame_err = 1; FSM in BREAK until rx high. Then 0x81 received cleanly.
6. Assert reset_n low at data bit 4 of a frame -> all outputs go to 0 immediately; after release, the remainder of the aborted frame produces no word (or at most a frame that fails checks); the following 0xC3 is received correctly.
